hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
Pipeline hazard and redirect controller for the 5-stage CPU (PC, BF0..BF3 pipeline buffers).
- Detects load-use hazards, stalls PC/BF0 and injects a bubble into BF1.
- Squashes younger instructions when a branch or jump resolves in MEM (BF2 outputs).
- Generates forwarding selects for both ALU operands.
- Sits beside the datapath; all outputs drive PC/BF write-enables, flushes and operand muxes.

Parameters:
REG_ADDR_W, 5, register address width
LOAD_STALL_CYCLES, 1, bubble cycles inserted per load-use hazard (1..7, for slower data memory)
CNT_W, 16, width of performance counters

Ports:
clk_HZ  in  1  CPU clock, rising edge
rst_HZ  in  1  asynchronous reset, active-high
rs_ID  in  REG_ADDR_W  rs field of instruction in BF0 output
rt_ID  in  REG_ADDR_W  rt field of instruction in BF0 output
rs_EX  in  REG_ADDR_W  rs of instruction in BF1 output
rt_EX  in  REG_ADDR_W  rt of instruction in BF1 output
memRead_EX  in  1  MemRead bit of BF1 M field
dst_MEM  in  REG_ADDR_W  mux2Output of BF2
regWrite_MEM  in  1  RegWrite of BF2 WB field
dst_WB  in  REG_ADDR_W  mux2Output of BF3
regWrite_WB  in  1  RegWrite_BF3
branchTaken_MEM  in  1  branch_BF2 AND zf_BF2
jump_MEM  in  1  jump_BF2
pcWrite_HZ  out  1  PC load enable
bf0Write_HZ  out  1  BF0 load enable
bf0Flush_HZ  out  1  BF0 loads NOP
bf1Flush_HZ  out  1  BF1 loads bubble (all control fields 0)
bf2Flush_HZ  out  1  BF2 loads bubble
fwdA_HZ  out  2  ALU x select: 00 regfile, 01 WB data, 10 MEM ALU result
fwdB_HZ  out  2  ALU y select, same encoding
stallCnt_HZ  out  CNT_W  stall cycles (optional feature)
flushCnt_HZ  out  CNT_W  redirect events (optional feature)

Behaviour:
- Clocking and reset: clk_HZ is the only clock. rst_HZ is asynchronous and active-high.
- While rst_HZ=1:
  - State is RUN and the stall counter is 0.
  - pcWrite_HZ=0 and bf0Write_HZ=0.
  - All three flush outputs are 1, holding the pipeline empty.
  - fwdA_HZ and fwdB_HZ are 00. Performance counters are 0.
- First edge after deassertion: normal RUN outputs.
- FSM states: RUN, STALL, REDIR.
- RUN: pcWrite=1, bf0Write=1, all flushes 0.
- Load-use hazard: memRead_EX=1 and rt_EX!=0 and (rt_EX==rs_ID or rt_EX==rt_ID).
  - Same cycle: pcWrite=0, bf0Write=0, bf1Flush=1.
  - If LOAD_STALL_CYCLES>1, go to STALL with counter=LOAD_STALL_CYCLES-1; otherwise stay in RUN. The bubble clears memRead_EX on the next cycle.
- STALL: pcWrite=0, bf0Write=0, bf1Flush=1, counter decrements each cycle. When counter reaches 1, return to RUN on the next edge.
- Redirect: branchTaken_MEM or jump_MEM, in any state.
  - Same cycle: pcWrite=1 (PC takes the redirect target), bf0Write=1, bf0Flush=1, bf1Flush=1, bf2Flush=1.
  - Next state is REDIR. Any stall in progress is abandoned and the counter cleared.
- REDIR (1 cycle):
  - Hazard detection is masked, because BF0/BF1 contain bubbles.
  - Outputs are the same as RUN.
  - Returns to RUN. A redirect in REDIR is handled as in RUN.
- Priority: redirect > STALL > load-use > RUN.
- Forwarding (combinational, active in every state):
  - fwdA = 10 if regWrite_MEM and dst_MEM!=0 and dst_MEM==rs_EX.
  - Else fwdA = 01 if regWrite_WB and dst_WB!=0 and dst_WB==rs_EX.
  - Else fwdA = 00.
  - fwdB uses the same rules with rt_EX.
  - MEM has priority over WB. Register 0 is never forwarded.
- No combinational path from outputs back to inputs. All state updates occur on the clk_HZ rising edge.

Optional Feature:
- Macro: HZ_PERF_CNT_EN.
- Defined:
  - stallCnt_HZ increments each cycle pcWrite_HZ=0 outside reset.
  - flushCnt_HZ increments on each redirect cycle.
  - Both counters saturate at all-ones and clear on rst_HZ.
- Undefined: both outputs are constant 0 and no counter flops are generated.

Test Plan:
- Reset: hold rst_HZ=1 → pcWrite=0, bf0Write=0, flushes=1/1/1, fwd=00. Release → next cycle pcWrite=1, flushes=0.
- Load-use, LOAD_STALL_CYCLES=1: memRead_EX=1, rt_EX=5, rs_ID=5 → exactly one cycle of pcWrite=0, bf1Flush=1, then RUN. Repeat with rt_EX=0 → no stall.
- LOAD_STALL_CYCLES=3 with the same hazard → 3 consecutive stall cycles. Assert jump_MEM in the 2nd stall cycle → stall aborts, flushes=1/1/1, pcWrite=1, REDIR, then RUN.
- Forwarding: dst_MEM=dst_WB=7, both regWrite=1, rs_EX=7, rt_EX=7 → fwdA=fwdB=10. Drop regWrite_MEM → 01. Set dst=0 → 00.
- Simultaneous load-use and branchTaken_MEM=1 → redirect wins (pcWrite=1, all flushes=1, no stall). Next cycle REDIR masks a persisting hazard.
- With HZ_PERF_CNT_EN: one 3-cycle stall plus two redirects → stallCnt=3, flushCnt=2. Assert rst_HZ mid-stall → both 0, state RUN.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Load-use stall, branch/jump redirect and operand-forwarding control for the 5-stage pipeline.
// Optional performance counters are built when HZ_PERF_CNT_EN is defined.
module hazard_ctrl #(
  parameter int REG_ADDR_W        = 5,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 16
) (
  input  logic                  clk_HZ,
  input  logic                  rst_HZ,
  input  logic [REG_ADDR_W-1:0] rs_ID,
  input  logic [REG_ADDR_W-1:0] rt_ID,
  input  logic [REG_ADDR_W-1:0] rs_EX,
  input  logic [REG_ADDR_W-1:0] rt_EX,
  input  logic                  memRead_EX,
  input  logic [REG_ADDR_W-1:0] dst_MEM,
  input  logic                  regWrite_MEM,
  input  logic [REG_ADDR_W-1:0] dst_WB,
  input  logic                  regWrite_WB,
  input  logic                  branchTaken_MEM,
  input  logic                  jump_MEM,
  output logic                  pcWrite_HZ,
  output logic                  bf0Write_HZ,
  output logic                  bf0Flush_HZ,
  output logic                  bf1Flush_HZ,
  output logic                  bf2Flush_HZ,
  output logic [1:0]            fwdA_HZ,
  output logic [1:0]            fwdB_HZ,
  output logic [CNT_W-1:0]      stallCnt_HZ,
  output logic [CNT_W-1:0]      flushCnt_HZ
);

  typedef enum logic [1:0] {RUN, STALL, REDIR} state_t;

  state_t     state_reg, state_next;
  logic [2:0] cnt_reg, cnt_next;

  logic load_use;
  logic redirect;

  assign load_use = memRead_EX && (rt_EX != '0) && ((rt_EX == rs_ID) || (rt_EX == rt_ID));
  assign redirect = branchTaken_MEM || jump_MEM;

  always_ff @(posedge clk_HZ or posedge rst_HZ) begin
    if (rst_HZ) begin
      state_reg <= RUN;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    pcWrite_HZ  = 1'b1;
    bf0Write_HZ = 1'b1;
    bf0Flush_HZ = 1'b0;
    bf1Flush_HZ = 1'b0;
    bf2Flush_HZ = 1'b0;
    if (redirect) begin
      bf0Flush_HZ = 1'b1;
      bf1Flush_HZ = 1'b1;
      bf2Flush_HZ = 1'b1;
      state_next  = REDIR;
      cnt_next    = '0;
    end else begin
      case (state_reg)
        STALL: begin
          pcWrite_HZ  = 1'b0;
          bf0Write_HZ = 1'b0;
          bf1Flush_HZ = 1'b1;
          if (cnt_reg <= 3'd1) begin
            state_next = RUN;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg - 3'd1;
          end
        end
        // BF0/BF1 hold bubbles here, so any apparent hazard is stale.
        REDIR: state_next = RUN;
        default: begin
          if (load_use) begin
            pcWrite_HZ  = 1'b0;
            bf0Write_HZ = 1'b0;
            bf1Flush_HZ = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
              state_next = STALL;
              cnt_next   = 3'(LOAD_STALL_CYCLES - 1);
            end
          end
        end
      endcase
    end
    if (rst_HZ) begin
      pcWrite_HZ  = 1'b0;
      bf0Write_HZ = 1'b0;
      bf0Flush_HZ = 1'b1;
      bf1Flush_HZ = 1'b1;
      bf2Flush_HZ = 1'b1;
    end
  end

  // MEM result is younger than WB, so it wins; r0 is hardwired zero.
  always_comb begin
    fwdA_HZ = 2'b00;
    fwdB_HZ = 2'b00;
    if (!rst_HZ) begin
      if (regWrite_MEM && (dst_MEM != '0) && (dst_MEM == rs_EX))     fwdA_HZ = 2'b10;
      else if (regWrite_WB && (dst_WB != '0) && (dst_WB == rs_EX))   fwdA_HZ = 2'b01;
      if (regWrite_MEM && (dst_MEM != '0) && (dst_MEM == rt_EX))     fwdB_HZ = 2'b10;
      else if (regWrite_WB && (dst_WB != '0) && (dst_WB == rt_EX))   fwdB_HZ = 2'b01;
    end
  end

`ifdef HZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_reg, flush_cnt_reg;

  always_ff @(posedge clk_HZ or posedge rst_HZ) begin
    if (rst_HZ) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (!pcWrite_HZ && (stall_cnt_reg != '1)) stall_cnt_reg <= stall_cnt_reg + 1'b1;
      if (redirect && (flush_cnt_reg != '1))    flush_cnt_reg <= flush_cnt_reg + 1'b1;
    end
  end

  assign stallCnt_HZ = stall_cnt_reg;
  assign flushCnt_HZ = flush_cnt_reg;
`else
  assign stallCnt_HZ = '0;
  assign flushCnt_HZ = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: two instances (1 and 3 stall cycles) share stimulus;
// a negedge monitor pops expected responses and compares.
module tb_hazard_ctrl;

  localparam int W = 5;
  localparam int CW = 16;
`ifdef HZ_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [W-1:0] rs_ID, rt_ID, rs_EX, rt_EX, dst_MEM, dst_WB;
  logic memRead_EX, regWrite_MEM, regWrite_WB, branchTaken_MEM, jump_MEM;

  logic pc1, bw1, f01, f11, f21, pc3, bw3, f03, f13, f23;
  logic [1:0] fa1, fb1, fa3, fb3;
  logic [CW-1:0] sc1, fc1, sc3, fc3;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_ADDR_W(W), .LOAD_STALL_CYCLES(1), .CNT_W(CW)) u_dut1 (
    .clk_HZ(clk), .rst_HZ(rst), .rs_ID(rs_ID), .rt_ID(rt_ID), .rs_EX(rs_EX), .rt_EX(rt_EX),
    .memRead_EX(memRead_EX), .dst_MEM(dst_MEM), .regWrite_MEM(regWrite_MEM), .dst_WB(dst_WB),
    .regWrite_WB(regWrite_WB), .branchTaken_MEM(branchTaken_MEM), .jump_MEM(jump_MEM),
    .pcWrite_HZ(pc1), .bf0Write_HZ(bw1), .bf0Flush_HZ(f01), .bf1Flush_HZ(f11), .bf2Flush_HZ(f21),
    .fwdA_HZ(fa1), .fwdB_HZ(fb1), .stallCnt_HZ(sc1), .flushCnt_HZ(fc1));

  hazard_ctrl #(.REG_ADDR_W(W), .LOAD_STALL_CYCLES(3), .CNT_W(CW)) u_dut3 (
    .clk_HZ(clk), .rst_HZ(rst), .rs_ID(rs_ID), .rt_ID(rt_ID), .rs_EX(rs_EX), .rt_EX(rt_EX),
    .memRead_EX(memRead_EX), .dst_MEM(dst_MEM), .regWrite_MEM(regWrite_MEM), .dst_WB(dst_WB),
    .regWrite_WB(regWrite_WB), .branchTaken_MEM(branchTaken_MEM), .jump_MEM(jump_MEM),
    .pcWrite_HZ(pc3), .bf0Write_HZ(bw3), .bf0Flush_HZ(f03), .bf1Flush_HZ(f13), .bf2Flush_HZ(f23),
    .fwdA_HZ(fa3), .fwdB_HZ(fb3), .stallCnt_HZ(sc3), .flushCnt_HZ(fc3));

  typedef struct {
    bit         is_cnt;
    string      nm;
    logic [4:0] c1;
    logic [4:0] c3;
    logic [1:0] fa;
    logic [1:0] fb;
    int         s1, l1, s3, l3;
  } exp_t;

  exp_t q[$];
  int n_pass = 0;
  int n_total = 0;

  // control vector bit order: {pcWrite, bf0Write, bf0Flush, bf1Flush, bf2Flush}
  localparam logic [4:0] C_RUN = 5'b11000;
  localparam logic [4:0] C_STL = 5'b00010;
  localparam logic [4:0] C_RDR = 5'b11111;
  localparam logic [4:0] C_RST = 5'b00111;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic vec(input string nm, input logic [4:0] c1, input logic [4:0] c3,
                     input logic [1:0] fa, input logic [1:0] fb);
    exp_t e;
    e.is_cnt = 1'b0; e.nm = nm; e.c1 = c1; e.c3 = c3; e.fa = fa; e.fb = fb;
    e.s1 = 0; e.l1 = 0; e.s3 = 0; e.l3 = 0;
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic cnt(input string nm, input int s1, input int l1, input int s3, input int l3);
    exp_t e;
    e.is_cnt = 1'b1; e.nm = nm; e.c1 = '0; e.c3 = '0; e.fa = '0; e.fb = '0;
    e.s1 = PERF ? s1 : 0; e.l1 = PERF ? l1 : 0; e.s3 = PERF ? s3 : 0; e.l3 = PERF ? l3 : 0;
    q.push_back(e);
  endtask

  task automatic hz(input logic mr, input logic [W-1:0] rt_ex, input logic [W-1:0] rs_id,
                    input logic [W-1:0] rt_id, input logic br, input logic jp);
    memRead_EX = mr; rt_EX = rt_ex; rs_ID = rs_id; rt_ID = rt_id;
    branchTaken_MEM = br; jump_MEM = jp;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front();
        if (e.is_cnt) begin
          check({e.nm, ".stall1"}, 32'(sc1), 32'(e.s1));
          check({e.nm, ".flush1"}, 32'(fc1), 32'(e.l1));
          check({e.nm, ".stall3"}, 32'(sc3), 32'(e.s3));
          check({e.nm, ".flush3"}, 32'(fc3), 32'(e.l3));
          $display("[%0t] %s counters s1=%0d f1=%0d s3=%0d f3=%0d", $time, e.nm, sc1, fc1, sc3, fc3);
        end else begin
          check({e.nm, ".ctrl1"}, 32'({pc1, bw1, f01, f11, f21}), 32'(e.c1));
          check({e.nm, ".ctrl3"}, 32'({pc3, bw3, f03, f13, f23}), 32'(e.c3));
          check({e.nm, ".fwd1"}, 32'({fa1, fb1}), 32'({e.fa, e.fb}));
          check({e.nm, ".fwd3"}, 32'({fa3, fb3}), 32'({e.fa, e.fb}));
          $display("[%0t] %s ctrl1=%b ctrl3=%b fwdA=%b fwdB=%b", $time, e.nm,
                   {pc1, bw1, f01, f11, f21}, {pc3, bw3, f03, f13, f23}, fa3, fb3);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    rs_ID = '0; rt_ID = '0; rs_EX = '0; rt_EX = '0; dst_MEM = '0; dst_WB = '0;
    memRead_EX = 0; regWrite_MEM = 0; regWrite_WB = 0; branchTaken_MEM = 0; jump_MEM = 0;
    @(posedge clk); #1;

    vec("reset", C_RST, C_RST, 2'b00, 2'b00);
    rs_EX = 7; dst_MEM = 7; regWrite_MEM = 1;
    vec("reset_fwd_mask", C_RST, C_RST, 2'b00, 2'b00);
    rs_EX = 0; dst_MEM = 0; regWrite_MEM = 0;
    rst = 1'b0;
    cnt("after_reset", 0, 0, 0, 0);
    vec("release", C_RUN, C_RUN, 2'b00, 2'b00);

    hz(1, 5, 5, 0, 0, 0); vec("lu_rs", C_STL, C_STL, 2'b00, 2'b00);
    hz(0, 0, 0, 0, 0, 0); vec("lu_stall2", C_RUN, C_STL, 2'b00, 2'b00);
    vec("lu_stall3", C_RUN, C_STL, 2'b00, 2'b00);
    cnt("after_stall", 1, 0, 3, 0);
    vec("lu_done", C_RUN, C_RUN, 2'b00, 2'b00);
    hz(1, 0, 0, 0, 0, 0); vec("lu_rt0", C_RUN, C_RUN, 2'b00, 2'b00);

    hz(1, 9, 0, 9, 0, 0); vec("lu_rt", C_STL, C_STL, 2'b00, 2'b00);
    hz(0, 0, 0, 0, 0, 1); vec("jump_in_stall", C_RDR, C_RDR, 2'b00, 2'b00);
    hz(1, 9, 0, 9, 0, 0); vec("redir_mask", C_RUN, C_RUN, 2'b00, 2'b00);
    hz(0, 0, 0, 0, 0, 0);
    cnt("after_jump", 2, 1, 4, 1);
    vec("run_after_jump", C_RUN, C_RUN, 2'b00, 2'b00);

    hz(1, 5, 5, 0, 1, 0); vec("br_and_lu", C_RDR, C_RDR, 2'b00, 2'b00);
    hz(1, 5, 5, 0, 0, 0); vec("redir_mask2", C_RUN, C_RUN, 2'b00, 2'b00);
    hz(0, 0, 0, 0, 1, 0); vec("br_in_redir", C_RDR, C_RDR, 2'b00, 2'b00);
    hz(0, 0, 0, 0, 0, 0); vec("redir", C_RUN, C_RUN, 2'b00, 2'b00);
    cnt("after_branches", 2, 3, 4, 3);
    vec("run", C_RUN, C_RUN, 2'b00, 2'b00);

    dst_MEM = 7; dst_WB = 7; regWrite_MEM = 1; regWrite_WB = 1; rs_EX = 7; rt_EX = 7;
    vec("fwd_mem", C_RUN, C_RUN, 2'b10, 2'b10);
    regWrite_MEM = 0; vec("fwd_wb", C_RUN, C_RUN, 2'b01, 2'b01);
    regWrite_MEM = 1; dst_MEM = 0; dst_WB = 0; vec("fwd_r0", C_RUN, C_RUN, 2'b00, 2'b00);
    dst_MEM = 3; dst_WB = 4; rs_EX = 3; rt_EX = 4; vec("fwd_mix", C_RUN, C_RUN, 2'b10, 2'b01);
    dst_MEM = 4; vec("fwd_mix2", C_RUN, C_RUN, 2'b00, 2'b10);
    dst_MEM = 0; dst_WB = 0; regWrite_MEM = 0; regWrite_WB = 0; rs_EX = 0; rt_EX = 0;

    hz(1, 5, 5, 0, 0, 0); vec("lu_again", C_STL, C_STL, 2'b00, 2'b00);
    hz(0, 0, 0, 0, 0, 0);
    cnt("mid_stall", 3, 3, 5, 3);
    vec("mid_stall", C_RUN, C_STL, 2'b00, 2'b00);
    rst = 1'b1;
    cnt("reset_mid", 0, 0, 0, 0);
    vec("reset_mid", C_RST, C_RST, 2'b00, 2'b00);
    rst = 1'b0;
    vec("post_reset", C_RUN, C_RUN, 2'b00, 2'b00);
    vec("post_reset2", C_RUN, C_RUN, 2'b00, 2'b00);

    @(negedge clk); #1;
    n_total++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending expected 0", q.size());
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
